// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, result flags and controller states.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_SRL  = 3'b010,
      OP_NOR  = 3'b011,
      OP_NAND = 3'b100,
      OP_SLL  = 3'b101,
      OP_SRA  = 3'b110,
      OP_MUL  = 3'b111
   } alu_op_t;

   typedef struct packed {
      logic z;
      logic c;
      logic n;
      logic v;
   } alu_flags_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the register-file read stage and writeback.
interface alu_seq_if #(parameter int WIDTH = 8);
   import alu_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] rs1;
   logic [WIDTH-1:0] rs2;
   alu_op_t          ctrl;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             flag_z;
   logic             flag_c;
   logic             flag_n;
   logic             flag_v;

   modport master (
      output in_valid, rs1, rs2, ctrl, out_ready,
      input  in_ready, out_valid, out, flag_z, flag_c, flag_n, flag_v
   );

   modport slave (
      input  in_valid, rs1, rs2, ctrl, out_ready,
      output in_ready, out_valid, out, flag_z, flag_c, flag_n, flag_v
   );

endinterface

// File: rtl/adder_n.sv
// Parametrised ripple-carry adder shared by ADD, SUB and the multiply accumulate step.
module adder_n #(
   parameter int WIDTH = 8
) (
   input  logic             cin,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] S,
   output logic             Cout
);

   logic [WIDTH:0] carry;

   assign carry[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign S[i]       = A[i] ^ B[i] ^ carry[i];
      assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
   end

   assign Cout = carry[WIDTH];

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops, bit-serial shifts and shift-add multiply,
// with valid/ready on both sides and registered result plus ZCNV flags.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     flush,
   alu_seq_if.slave bus
);

   localparam int CW = SHW + 1;

   alu_state_t       state;
   alu_op_t          op_q;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] out_q;
   logic [CW-1:0]    cnt;
   alu_flags_t       flags_q;

   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH-1:0] add_s;
   logic             add_cin;
   logic             add_cout;

   logic             accept;
   logic [SHW-1:0]   amt;
   logic             ctrl_is_shift;
   logic [WIDTH-1:0] sh_next;
   logic             sh_bit;
   logic [WIDTH-1:0] res;
   logic             res_c;
   logic             res_v;
   alu_flags_t       res_flags;

   assign amt           = bus.rs2[SHW-1:0];
   assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
   assign accept        = bus.in_valid & bus.in_ready & ~flush;
   assign ctrl_is_shift = (bus.ctrl == OP_SRL) | (bus.ctrl == OP_SLL) | (bus.ctrl == OP_SRA);

   // While busy the adder accumulates the multiplicand into the product high half;
   // otherwise it works directly on the offered operands so ADD/SUB finish at accept.
   always_comb begin
      add_a   = bus.rs1;
      add_b   = bus.rs2;
      add_cin = 1'b0;
      if (state == BUSY) begin
         add_a = hi;
         add_b = work[0] ? mcand : '0;
      end else if (bus.ctrl == OP_SUB) begin
         add_b   = ~bus.rs2;
         add_cin = 1'b1;
      end
   end

   adder_n #(.WIDTH(WIDTH)) u_adder (
      .cin  (add_cin),
      .A    (add_a),
      .B    (add_b),
      .S    (add_s),
      .Cout (add_cout)
   );

   // One-bit shift step; sh_bit is the bit falling off the end this cycle.
   always_comb begin
      sh_next = work;
      sh_bit  = 1'b0;
      case (op_q)
         OP_SRL: begin
            sh_next = {1'b0, work[WIDTH-1:1]};
            sh_bit  = work[0];
         end
         OP_SLL: begin
            sh_next = {work[WIDTH-2:0], 1'b0};
            sh_bit  = work[WIDTH-1];
         end
         OP_SRA: begin
            sh_next = {work[WIDTH-1], work[WIDTH-1:1]};
            sh_bit  = work[0];
         end
         default: ;
      endcase
   end

   // Result and flags that get registered either at accept (single-cycle ops and
   // zero-amount shifts) or on the last busy cycle.
   always_comb begin
      res   = bus.rs1;
      res_c = 1'b0;
      res_v = 1'b0;
      if (state == BUSY) begin
         if (op_q == OP_MUL) begin
            res   = {add_s[0], work[WIDTH-1:1]};
            res_c = add_cout | (|add_s[WIDTH-1:1]);
            res_v = res_c;
         end else begin
            res   = sh_next;
            res_c = sh_bit;
         end
      end else begin
         case (bus.ctrl)
            OP_ADD, OP_SUB: begin
               res   = add_s;
               res_c = add_cout;
               res_v = (add_a[WIDTH-1] == add_b[WIDTH-1]) & (add_s[WIDTH-1] != add_a[WIDTH-1]);
            end
            OP_NOR:  res = ~(bus.rs1 | bus.rs2);
            OP_NAND: res = ~(bus.rs1 & bus.rs2);
            default: ;
         endcase
      end
      res_flags.z = (res == '0);
      res_flags.c = res_c;
      res_flags.n = res[WIDTH-1];
      res_flags.v = res_v;
   end

   // Controller: flush wins over everything but reset, and a DONE accept retires and restarts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         op_q    <= OP_ADD;
         work    <= '0;
         hi      <= '0;
         mcand   <= '0;
         cnt     <= '0;
         out_q   <= '0;
         flags_q <= '0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  op_q  <= bus.ctrl;
                  work  <= bus.rs1;
                  mcand <= bus.rs1;
                  hi    <= '0;
                  if (bus.ctrl == OP_MUL) begin
                     work  <= bus.rs2;
                     cnt   <= CW'(WIDTH);
                     state <= BUSY;
                  end else if (ctrl_is_shift && (amt != '0)) begin
                     cnt   <= {1'b0, amt};
                     state <= BUSY;
                  end else begin
                     out_q   <= res;
                     flags_q <= res_flags;
                     state   <= DONE;
                  end
               end else if ((state == DONE) && bus.out_ready) begin
                  state <= IDLE;
               end
            end
            BUSY: begin
               cnt <= cnt - 1'b1;
               if (op_q == OP_MUL) begin
                  {hi, work} <= {add_cout, add_s, work[WIDTH-1:1]};
               end else begin
                  work <= sh_next;
               end
               if (cnt == CW'(1)) begin
                  out_q   <= res;
                  flags_q <= res_flags;
                  state   <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.out_valid = (state == DONE);
   assign bus.out       = out_q;
   assign bus.flag_z    = flags_q.z;
   assign bus.flag_c    = flags_q.c;
   assign bus.flag_n    = flags_q.n;
   assign bus.flag_v    = flags_q.v;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases at WIDTH=8/16 plus random ops against a behavioural model.
module tb_alu_seq;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   checks = 0;
   int   errors = 0;

   alu_seq_if #(.WIDTH(8))  b8();
   alu_seq_if #(.WIDTH(16)) b16();

   alu_seq #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (b8.slave)
   );

   alu_seq #(.WIDTH(16)) dut16 (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (b16.slave)
   );

   always #5 clk = ~clk;

   // Arithmetic reference: result, {z,c,n,v} and extra cycles after the accept edge.
   task automatic model8(input alu_op_t op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r, output logic [3:0] f, output int lat);
      int          sa, sb, si, k;
      logic [8:0]  s;
      logic [15:0] p;
      logic        c, v;
      sa = $signed(a);
      sb = $signed(b);
      k  = b % 8;
      c  = 1'b0;
      v  = 1'b0;
      lat = 0;
      case (op)
         OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; si = sa + sb; v = (si > 127) || (si < -128); end
         OP_SUB: begin s = {1'b0, a} + {1'b0, ~b} + 9'd1; r = s[7:0]; c = s[8]; si = sa - sb; v = (si > 127) || (si < -128); end
         OP_SRL: begin r = a >> k; c = (k == 0) ? 1'b0 : a[k-1]; lat = k; end
         OP_SLL: begin r = a << k; c = (k == 0) ? 1'b0 : a[8-k]; lat = k; end
         OP_SRA: begin r = 8'($signed(a) >>> k); c = (k == 0) ? 1'b0 : a[k-1]; lat = k; end
         OP_NOR:  r = ~(a | b);
         OP_NAND: r = ~(a & b);
         default: begin p = 16'(a) * 16'(b); r = p[7:0]; c = (p[15:8] != 0); v = c; lat = 8; end
      endcase
      f = {(r == 8'h00), c, r[7], v};
   endtask

   // Drives one op, scrambles inputs after accept, waits (bounded) for the result,
   // optionally holds out_ready low for 'stall' cycles, then retires it.
   task automatic issue8(input alu_op_t op, input logic [7:0] a, input logic [7:0] b, input int stall,
                         output logic [7:0] r1, output logic [3:0] f1, output int lat,
                         output logic [7:0] r2, output logic [3:0] f2);
      @(negedge clk);
      b8.ctrl = op; b8.rs1 = a; b8.rs2 = b; b8.in_valid = 1'b1; b8.out_ready = (stall == 0);
      @(posedge clk); #1;
      b8.in_valid = 1'b0;
      b8.rs1 = 8'($urandom); b8.rs2 = 8'($urandom); b8.ctrl = alu_op_t'($urandom_range(0, 7));
      lat = 0;
      while (b8.out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
      if (lat >= 40) lat = -1;
      r1 = b8.out; f1 = {b8.flag_z, b8.flag_c, b8.flag_n, b8.flag_v};
      repeat (stall) begin @(posedge clk); #1; end
      r2 = b8.out; f2 = {b8.flag_z, b8.flag_c, b8.flag_n, b8.flag_v};
      b8.out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic issue16(input alu_op_t op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] r, output logic [3:0] f, output int lat);
      @(negedge clk);
      b16.ctrl = op; b16.rs1 = a; b16.rs2 = b; b16.in_valid = 1'b1; b16.out_ready = 1'b1;
      @(posedge clk); #1;
      b16.in_valid = 1'b0; b16.rs1 = 16'($urandom); b16.rs2 = 16'($urandom);
      lat = 0;
      while (b16.out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
      if (lat >= 40) lat = -1;
      r = b16.out; f = {b16.flag_z, b16.flag_c, b16.flag_n, b16.flag_v};
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #12;
      checks++; if ({b8.out_valid, b8.out} !== 9'h000) begin errors++; $display("[TB] FAIL reset_out: got %h required 000", {b8.out_valid, b8.out}); end
      checks++; if ({b8.flag_z, b8.flag_c, b8.flag_n, b8.flag_v} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags: got %b required 0000", {b8.flag_z, b8.flag_c, b8.flag_n, b8.flag_v}); end
      @(negedge clk); rst = 1'b0; #1;
      checks++; if (b8.in_ready !== 1'b1 || b16.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b%b required 11", b8.in_ready, b16.in_ready); end
   endtask

   task automatic test_add_sub();
      logic [7:0] r, r2; logic [3:0] f, f2; int lat;
      issue8(OP_ADD, 8'h7F, 8'h01, 0, r, f, lat, r2, f2);
      checks++; if (r !== 8'h80) begin errors++; $display("[TB] FAIL add_out: got %h required 80", r); end
      checks++; if (f !== 4'b0011) begin errors++; $display("[TB] FAIL add_flags: got %b required 0011", f); end
      checks++; if (lat !== 0) begin errors++; $display("[TB] FAIL add_latency: got %0d required 0", lat); end
      issue8(OP_SUB, 8'h05, 8'h05, 0, r, f, lat, r2, f2);
      checks++; if (r !== 8'h00) begin errors++; $display("[TB] FAIL sub_out: got %h required 00", r); end
      checks++; if (f !== 4'b1100) begin errors++; $display("[TB] FAIL sub_flags: got %b required 1100", f); end
   endtask

   task automatic test_shifts();
      logic [7:0] r, r2; logic [3:0] f, f2; int lat;
      issue8(OP_SRA, 8'h90, 8'h03, 0, r, f, lat, r2, f2);
      checks++; if ({r, f} !== {8'hF2, 4'b0010}) begin errors++; $display("[TB] FAIL sra_result: got %h/%b required f2/0010", r, f); end
      checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL sra_latency: got %0d required 3", lat); end
      issue8(OP_SLL, 8'h81, 8'h01, 0, r, f, lat, r2, f2);
      checks++; if ({r, f} !== {8'h02, 4'b0100}) begin errors++; $display("[TB] FAIL sll_result: got %h/%b required 02/0100", r, f); end
      checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL sll_latency: got %0d required 1", lat); end
      issue8(OP_SRL, 8'hFF, 8'h00, 0, r, f, lat, r2, f2);
      checks++; if ({r, f} !== {8'hFF, 4'b0010}) begin errors++; $display("[TB] FAIL srl0_result: got %h/%b required ff/0010", r, f); end
      checks++; if (lat !== 0) begin errors++; $display("[TB] FAIL srl0_latency: got %0d required 0", lat); end
   endtask

   task automatic test_mul();
      logic [7:0] r, r2; logic [3:0] f, f2; int lat;
      issue8(OP_MUL, 8'h10, 8'h11, 0, r, f, lat, r2, f2);
      checks++; if ({r, f} !== {8'h10, 4'b0101}) begin errors++; $display("[TB] FAIL mul_ovf_result: got %h/%b required 10/0101", r, f); end
      checks++; if (lat !== 8) begin errors++; $display("[TB] FAIL mul_latency: got %0d required 8", lat); end
      issue8(OP_MUL, 8'h0F, 8'h03, 0, r, f, lat, r2, f2);
      checks++; if ({r, f} !== {8'h2D, 4'b0000}) begin errors++; $display("[TB] FAIL mul_result: got %h/%b required 2d/0000", r, f); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      b8.ctrl = OP_NAND; b8.rs1 = 8'hF0; b8.rs2 = 8'h3C; b8.in_valid = 1'b1; b8.out_ready = 1'b0;
      @(posedge clk); #1;
      b8.in_valid = 1'b0;
      checks++; if ({b8.out_valid, b8.out} !== {1'b1, 8'hCF}) begin errors++; $display("[TB] FAIL nand_result: got %b/%h required 1/cf", b8.out_valid, b8.out); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({b8.out_valid, b8.in_ready, b8.out} !== {2'b10, 8'hCF}) begin
            errors++; $display("[TB] FAIL hold_cycle%0d: got valid=%b ready=%b out=%h required 1/0/cf", i, b8.out_valid, b8.in_ready, b8.out);
         end
      end
      @(negedge clk);
      b8.out_ready = 1'b1; b8.in_valid = 1'b1; b8.ctrl = OP_ADD; b8.rs1 = 8'h01; b8.rs2 = 8'h01;
      #1;
      checks++; if (b8.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready: got %b required 1", b8.in_ready); end
      @(posedge clk); #1;
      b8.in_valid = 1'b0;
      checks++; if ({b8.out_valid, b8.out} !== {1'b1, 8'h02}) begin errors++; $display("[TB] FAIL b2b_result: got %b/%h required 1/02", b8.out_valid, b8.out); end
      @(posedge clk); #1;
      checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_retire: got %b required 0", b8.out_valid); end
   endtask

   task automatic test_flush();
      logic [7:0] r, r2; logic [3:0] f, f2; int lat; int seen;
      issue8(OP_NOR, 8'h01, 8'h02, 0, r, f, lat, r2, f2);
      checks++; if ({r, f} !== {8'hFC, 4'b0010}) begin errors++; $display("[TB] FAIL nor_result: got %h/%b required fc/0010", r, f); end
      @(negedge clk);
      b8.ctrl = OP_SRL; b8.rs1 = 8'hFF; b8.rs2 = 8'h07; b8.in_valid = 1'b1;
      @(posedge clk); #1;
      b8.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      checks++; if ({b8.out_valid, b8.in_ready} !== 2'b01) begin errors++; $display("[TB] FAIL flush_idle: got valid=%b ready=%b required 0/1", b8.out_valid, b8.in_ready); end
      seen = 0;
      repeat (10) begin @(posedge clk); #1; if (b8.out_valid === 1'b1) seen++; end
      checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL flush_no_valid: got %0d valid cycles required 0", seen); end
      checks++; if (b8.out !== 8'hFC) begin errors++; $display("[TB] FAIL flush_out_kept: got %h required fc", b8.out); end
      @(negedge clk);
      b8.ctrl = OP_ADD; b8.rs1 = 8'h03; b8.rs2 = 8'h04; b8.in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      b8.in_valid = 1'b0; flush = 1'b0;
      @(posedge clk); #1;
      checks++; if ({b8.out_valid, b8.out} !== {1'b0, 8'hFC}) begin errors++; $display("[TB] FAIL flush_blocks_accept: got %b/%h required 0/fc", b8.out_valid, b8.out); end
   endtask

   task automatic test_reset_mid_mul();
      @(negedge clk);
      b8.ctrl = OP_MUL; b8.rs1 = 8'h0F; b8.rs2 = 8'h03; b8.in_valid = 1'b1;
      @(posedge clk); #1;
      b8.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++; if ({b8.out_valid, b8.out} !== 9'h000) begin errors++; $display("[TB] FAIL rst_mul_out: got %b/%h required 0/00", b8.out_valid, b8.out); end
      checks++; if ({b8.flag_z, b8.flag_c, b8.flag_n, b8.flag_v} !== 4'b0000) begin errors++; $display("[TB] FAIL rst_mul_flags: got %b required 0000", {b8.flag_z, b8.flag_c, b8.flag_n, b8.flag_v}); end
      @(negedge clk); rst = 1'b0; #1;
      checks++; if (b8.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mul_in_ready: got %b required 1", b8.in_ready); end
      repeat (10) @(posedge clk);
      #1;
      checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mul_no_result: got %b required 0", b8.out_valid); end
   endtask

   task automatic test_random();
      logic [7:0] a, b, er, r, r2; logic [3:0] ef, f, f2; int elat, lat, stall; alu_op_t op;
      for (int n = 0; n < 60; n++) begin
         op = alu_op_t'($urandom_range(0, 7));
         a = 8'($urandom); b = 8'($urandom);
         stall = $urandom_range(0, 3);
         model8(op, a, b, er, ef, elat);
         issue8(op, a, b, stall, r, f, lat, r2, f2);
         checks++; if ({r, f} !== {er, ef}) begin errors++; $display("[TB] FAIL rand%0d_op%0d(%h,%h): got %h/%b required %h/%b", n, op, a, b, r, f, er, ef); end
         checks++; if (lat !== elat) begin errors++; $display("[TB] FAIL rand%0d_latency: got %0d required %0d", n, lat, elat); end
         checks++; if ({r2, f2} !== {er, ef}) begin errors++; $display("[TB] FAIL rand%0d_hold: got %h/%b required %h/%b", n, r2, f2, er, ef); end
      end
   endtask

   task automatic test_width16();
      logic [15:0] r; logic [3:0] f; int lat;
      issue16(OP_ADD, 16'hFFFF, 16'h0001, r, f, lat);
      checks++; if ({r, f} !== {16'h0000, 4'b1100}) begin errors++; $display("[TB] FAIL w16_add: got %h/%b required 0000/1100", r, f); end
      issue16(OP_SLL, 16'h0001, 16'h000F, r, f, lat);
      checks++; if ({r, f} !== {16'h8000, 4'b0010}) begin errors++; $display("[TB] FAIL w16_sll: got %h/%b required 8000/0010", r, f); end
      checks++; if (lat !== 15) begin errors++; $display("[TB] FAIL w16_sll_latency: got %0d required 15", lat); end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0;
      b8.in_valid = 1'b0; b8.out_ready = 1'b1; b8.rs1 = '0; b8.rs2 = '0; b8.ctrl = OP_ADD;
      b16.in_valid = 1'b0; b16.out_ready = 1'b1; b16.rs1 = '0; b16.rs2 = '0; b16.ctrl = OP_ADD;
      test_reset();
      test_add_sub();
      test_shifts();
      test_mul();
      test_back_to_back();
      test_flush();
      test_reset_mid_mul();
      test_random();
      test_width16();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the 8-bit single-cycle ALU.
- Operand width is generic, and both input and output use valid/ready handshakes.
- Shifts execute iteratively, one bit per cycle; MUL is shift-add over WIDTH cycles.
- Results are registered with ZCNV flags. Sits between register-file read and writeback in the core datapath.

Parameters:
- WIDTH, 8, operand/result width; power of two, >= 4.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- flush  input  1  synchronous abort of any op in flight.
- in_valid  input  1  operation offered.
- in_ready  output  1  block can accept an operation.
- rs1  input  WIDTH  operand A.
- rs2  input  WIDTH  operand B; shifts use rs2[SHW-1:0] as amount.
- ctrl  input  3  opcode.
- out_valid  output  1  result held.
- out_ready  input  1  consumer takes result.
- out  output  WIDTH  result.
- flag_z  output  1  zero.
- flag_c  output  1  carry.
- flag_n  output  1  negative (out[WIDTH-1]).
- flag_v  output  1  overflow.

Behaviour:
- Opcodes: 000 ADD, 001 SUB (rs1+~rs2+1), 010 SRL, 011 NOR, 100 NAND, 101 SLL, 110 SRA, 111 MUL (low WIDTH bits of unsigned product). There is no illegal opcode.
- FSM states:
  - IDLE -> BUSY on accept (in_valid & in_ready), for a shift with amount > 0 or for MUL.
  - IDLE -> DONE on accept for any other op.
  - BUSY -> DONE when the iteration counter expires.
  - DONE -> IDLE on out_ready.
- Handshake:
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - Accepting in DONE while out_ready is high retires the old result and starts the new op in the same cycle (back-to-back).
  - out_valid = (state==DONE).
- Latency, with the accept at edge N:
  - ADD, SUB, NOR, NAND, or any shift with amount 0: out_valid at N+1.
  - Shift by k: out_valid at N+1+k.
  - MUL: out_valid at N+1+WIDTH.
- Operands and opcode are captured at accept. Later changes on rs1, rs2 and ctrl have no effect.
- out and flags are stable while out_valid=1 and out_ready=0. They change only on a new result or on reset.
- Flags:
  - Z: out==0, all ops.
  - N: out MSB, all ops.
  - ADD/SUB: C = adder carry-out (SUB: 1 means no borrow); V = signed overflow.
  - Shifts: C = last bit shifted out (0 when amount is 0); V = 0.
  - NOR/NAND: C = 0, V = 0.
  - MUL: C = V = (high WIDTH bits of product != 0).
- Iteration counter: SHW+1 bits. Loaded with the shift amount or with WIDTH, decrements once per BUSY cycle, and BUSY exits on reaching 1.
- flush: forces IDLE on the next edge. Any in-flight op or unconsumed result is discarded. out and flags keep their last values, but out_valid=0.
- flush takes priority over a same-cycle accept; that accept does not happen.
- rst at any time (including mid-MUL): state=IDLE, out=0, all flags=0, out_valid=0. in_ready=1 from the first cycle after rst deasserts.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [2:0] alu_op_t with the eight opcodes above;
  - packed struct alu_flags_t {z,c,n,v};
  - localparam state encodings IDLE/BUSY/DONE.
- Sub-module adder_n, a parametrised ripple adder with ports cin, A, B, S, Cout and parameter WIDTH.
  - One instance serves ADD, SUB and the MUL accumulate step.
  - Operand selection is muxed by the FSM.

Test Plan:
- Add and sub flags (WIDTH=8):
  - ADD 8'h7F + 8'h01 -> out 8'h80, N=1, V=1, C=0, Z=0, out_valid exactly one cycle after accept.
  - SUB 8'h05 - 8'h05 -> out 8'h00, Z=1, C=1, V=0.
- Shifts (WIDTH=8):
  - SRA 8'h90 by 3 -> out 8'hF2, C=0, out_valid at N+4.
  - SLL 8'h81 by 1 -> out 8'h02, C=1, out_valid at N+2.
  - SRL 8'hFF by 0 -> out 8'hFF, C=0, out_valid at N+1.
- Multiply (WIDTH=8):
  - MUL 8'h10 * 8'h11 -> out 8'h10, C=V=1, out_valid at N+9.
  - MUL 8'h0F * 8'h03 -> out 8'h2D, C=0.
- Backpressure and back-to-back:
  - out_ready=0 for 5 cycles after NAND 8'hF0,8'h3C -> out held at 8'hCF, in_ready=0 throughout.
  - Then out_ready=1 with in_valid=1 (ADD 1+1) in the same cycle -> old result retired, next result 8'h02 one cycle later.
- Reset and flush:
  - rst asserted at cycle 4 of MUL -> out=0, flags=0, out_valid=0 immediately (async), in_ready=1 after release.
  - flush during a shift by 7 -> IDLE next cycle, out_valid never asserts for that op.
- Parameter sweep:
  - WIDTH=16: ADD 16'hFFFF + 16'h0001 -> out 0, Z=1, C=1.
  - WIDTH=16: SLL by 15 on 16'h0001 -> 16'h8000 at N+16.
